gpio_port_ctrl: RTL and testbench

- Register-mapped controller for the DE-series 40-pin header: per-bit direction, output data, synchronized input, rising-edge capture and interrupt.
- Shares the header between two bus requesters (e.g. a processor-side master and a hardware test sequencer) through a round-robin arbiter.
- Sits between those masters and the top-level `GPIO` inout. It replaces the fixed all-Z tie-off, so pins are driven only where direction bits are set.

---
 rtl/gpio_port_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gpio_port_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl
// Register-mapped controller for a 40-pin style GPIO header shared by two
// bus requesters through a round-robin arbiter.
//
// Ports
//   CLOCK_50         system clock, all state on rising edge
//   Resetn           asynchronous active-low reset
//   GPIO[W]          header pins, bit i driven with DOUT[i] when DIR[i]=1, else Z
//   req[2]           request per requester, held until its ack
//   we[2]            write(1)/read(0) per requester
//   addr0/addr1[3]   register select per requester
//   wdata0/wdata1[W] write data per requester
//   ack[2]           one-cycle completion pulse per requester
//   rdata[W]         read data, valid only while ack is high
//   irq              high while |(EDGE & IE)
//   dbg_state_o[2]   current FSM state (IDLE=0, XFER=1, ACK=2)
//
// Handshake: a requester raises req[k] with we/addr/wdata and keeps req[k]
// high; the values are latched on the grant edge. ack[k] is high for exactly
// one cycle, and req[k] must be dropped by the edge that ends that cycle.
//
// Register map: 0 DIR, 1 DOUT, 2 DIN (ro), 3 EDGE (w1c), 4 IE, 5-7 read 0.
module gpio_port_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] DOUT_RST = '0
) (
   input  logic             CLOCK_50,
   input  logic             Resetn,
   inout  wire  [WIDTH-1:0] GPIO,
   input  logic [1:0]       req,
   input  logic [1:0]       we,
   input  logic [2:0]       addr0,
   input  logic [2:0]       addr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic [1:0]       ack,
   output logic [WIDTH-1:0] rdata,
   output logic             irq,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             we_q, we_d;
   logic [2:0]       addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] ie_q, ie_d;
   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [1:0]       ack_q, ack_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rd_mux;
   logic             win;

   // Pins drive only where the direction bit is set.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign GPIO[i] = dir_q[i] ? dout_q[i] : 1'bz;
   end

   // Output-configured bits never capture edges.
   assign rise = sync2_q & ~prev_q & ~dir_q;

   always_comb begin
      rd_mux = '0;
      case (addr_q)
         3'd0:    rd_mux = dir_q;
         3'd1:    rd_mux = dout_q;
         3'd2:    rd_mux = sync2_q;
         3'd3:    rd_mux = edge_q;
         3'd4:    rd_mux = ie_q;
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      dir_d   = dir_q;
      dout_d  = dout_q;
      ie_d    = ie_q;
      ack_d   = ack_q;
      rdata_d = rdata_q;
      clr     = '0;
      win     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               // On contention the requester not served last wins.
               win     = (req == 2'b11) ? ~last_q : req[1];
               owner_d = win;
               we_d    = we[win];
               addr_d  = win ? addr1 : addr0;
               wdata_d = win ? wdata1 : wdata0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (we_q) begin
               case (addr_q)
                  3'd0:    dir_d  = wdata_q;
                  3'd1:    dout_d = wdata_q;
                  3'd3:    clr    = wdata_q;
                  3'd4:    ie_d   = wdata_q;
                  default: ;
               endcase
            end else begin
               rdata_d = rd_mux;
            end
            ack_d   = owner_q ? 2'b10 : 2'b01;
            last_d  = owner_q;
            state_d = ACK;
         end
         ACK: begin
            ack_d   = 2'b00;
            rdata_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A rise in the same cycle as its clear leaves the bit set.
      edge_d = (edge_q & ~clr) | rise;
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= 1'b1;
         dir_q   <= '0;
         dout_q  <= DOUT_RST;
         edge_q  <= '0;
         ie_q    <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         dir_q   <= dir_d;
         dout_q  <= dout_d;
         edge_q  <= edge_d;
         ie_q    <= ie_d;
         sync1_q <= GPIO;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   assign ack         = ack_q;
   assign rdata       = rdata_q;
   assign irq         = |(edge_q & ie_q);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
module tb_gpio_port_ctrl;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   logic [1:0]   req = '0;
   logic [1:0]   we = '0;
   logic [2:0]   addr0 = '0, addr1 = '0;
   logic [W-1:0] wdata0 = '0, wdata1 = '0;
   logic [1:0]   ack;
   logic [W-1:0] rdata;
   logic         irq;
   logic [1:0]   dbg_state;

   // External pin drivers: tb_oe selects which pins the bench drives.
   logic [W-1:0] tb_oe  = '1;
   logic [W-1:0] tb_val = '0;
   wire  [W-1:0] gpio;
   for (genvar i = 0; i < W; i++) begin : g_ext
      assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
   end

   gpio_port_ctrl #(.WIDTH(W), .DOUT_RST('0)) dut (
      .CLOCK_50    (clk),
      .Resetn      (rst_n),
      .GPIO        (gpio),
      .req         (req),
      .we          (we),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .ack         (ack),
      .rdata       (rdata),
      .irq         (irq),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   // Entry = {owner, expected rdata}; writes expect rdata 0.
   logic [W:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: whenever an ack is presented, pop and compare.
   initial begin
      logic [W:0] e;
      logic [1:0] exp_ack;
      forever begin
         @(negedge clk);
         if (ack != 2'b00) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_ack: got ack=%b with empty queue", ack);
            end else begin
               e = exp_q.pop_front();
               exp_ack = e[W] ? 2'b10 : 2'b01;
               check("ack_owner", {30'd0, ack}, {30'd0, exp_ack});
               check("rdata", rdata, e[W-1:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Entered and left just after a negedge; leaves the FSM back in IDLE.
   task automatic access(input int k, input logic w, input logic [2:0] a,
                         input logic [W-1:0] d, input logic [W-1:0] rd_exp);
      int n;
      exp_q.push_back({k[0], (w ? {W{1'b0}} : rd_exp)});
      we[k] = w;
      if (k == 0) begin addr0 = a; wdata0 = d; end
      else        begin addr1 = a; wdata1 = d; end
      req[k] = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!ack[k] && n < 8);
      check("ack_latency", n, 2);
      req[k] = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acks;
      int n;

      repeat (3) @(negedge clk);
      check("rst_ack", {30'd0, ack}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset values
      access(0, 1'b0, 3'd0, '0, 32'h0);
      access(0, 1'b0, 3'd1, '0, 32'h0);
      access(0, 1'b0, 3'd3, '0, 32'h0);
      access(0, 1'b0, 3'd4, '0, 32'h0);
      tb_val = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check("pins_undriven", gpio, 32'h1234_5678);
      access(0, 1'b0, 3'd2, '0, 32'h1234_5678);

      // Low byte becomes output
      tb_oe = 32'hFFFF_FF00;
      access(0, 1'b1, 3'd0, 32'h0000_00FF, '0);
      access(0, 1'b1, 3'd1, 32'h0000_00A5, '0);
      check("pins_driven", gpio, 32'h1234_56A5);
      access(0, 1'b0, 3'd2, '0, 32'h1234_56A5);

      // Requester 1 served last, so requester 0 wins the contention below
      access(1, 1'b0, 3'd0, '0, 32'h0000_00FF);

      // Contention: five transfers, expected order 0,1,0,1,0
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b1, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b1, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      we = 2'b11; addr0 = 3'd1; addr1 = 3'd1;
      wdata0 = 32'h1; wdata1 = 32'h2;
      req = 2'b11;
      acks = 0;
      n = 0;
      while (acks < 5 && n < 40) begin
         @(negedge clk);
         n++;
         if (ack != 2'b00) acks++;
      end
      check("contention_acks", acks, 5);
      req = 2'b00;
      @(negedge clk);
      access(0, 1'b0, 3'd1, '0, 32'h1);

      // Edge capture and interrupt
      access(0, 1'b1, 3'd0, 32'h0, '0);
      tb_oe = '1;
      tb_val = '0;
      repeat (4) @(negedge clk);
      access(0, 1'b1, 3'd3, 32'hFFFF_FFFF, '0);
      access(0, 1'b0, 3'd3, '0, 32'h0);
      access(1, 1'b1, 3'd4, 32'h1, '0);
      check("irq_idle", {31'd0, irq}, 32'd0);
      tb_val[0] = 1'b1;
      @(negedge clk);
      check("irq_c1", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_c2", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_c3", {31'd0, irq}, 32'd1);
      access(0, 1'b1, 3'd3, 32'h1, '0);
      check("irq_cleared", {31'd0, irq}, 32'd0);
      tb_val[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("irq_fall", {31'd0, irq}, 32'd0);
      // Rise reaches EDGE on the same edge as the clear
      tb_val[0] = 1'b1;
      @(negedge clk);
      access(0, 1'b1, 3'd3, 32'h1, '0);
      access(0, 1'b0, 3'd3, '0, 32'h1);
      check("irq_rise_on_clear", {31'd0, irq}, 32'd1);

      // Toggling an output-configured bit captures nothing
      access(0, 1'b1, 3'd3, 32'hFFFF_FFFF, '0);
      tb_oe = 32'hFFFF_FFFD;
      access(0, 1'b1, 3'd0, 32'h2, '0);
      access(0, 1'b1, 3'd1, 32'h2, '0);
      access(1, 1'b1, 3'd1, 32'h0, '0);
      access(0, 1'b1, 3'd1, 32'h2, '0);
      repeat (4) @(negedge clk);
      access(0, 1'b0, 3'd3, '0, 32'h0);

      // Unmapped address
      access(1, 1'b1, 3'd6, 32'hFFFF_FFFF, '0);
      access(0, 1'b0, 3'd0, '0, 32'h2);
      access(0, 1'b0, 3'd1, '0, 32'h2);
      access(0, 1'b0, 3'd4, '0, 32'h1);
      access(1, 1'b0, 3'd6, '0, 32'h0);

      // Reset during XFER of a DIR write
      we[0] = 1'b1; addr0 = 3'd0; wdata0 = 32'hFFFF_FFFF;
      req = 2'b01;
      @(posedge clk);
      @(negedge clk);
      check("xfer_state", {30'd0, dbg_state}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ack", {30'd0, ack}, 32'd0);
      check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
      req = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      access(0, 1'b0, 3'd0, '0, 32'h0);
      tb_oe = '1;
      tb_val = 32'hCAFE_F00D;
      repeat (3) @(negedge clk);
      check("pins_after_rst", gpio, 32'hCAFE_F00D);
      access(0, 1'b0, 3'd2, '0, 32'hCAFE_F00D);

      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule
